// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32I pipeline control logic.
//   fwd_sel_t   - operand forwarding select driven into the E-stage muxes
//   mem_fsm_t   - states of the data-memory wait controller
//   RESULT_LOAD - ResultSrc encoding that marks a load instruction
package core_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,   // operand from the register file
        FWD_W  = 2'b01,   // operand from the W-stage result
        FWD_M  = 2'b10    // operand from the M-stage ALU result
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_fsm_t;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that increments when inc is high and holds at
// all-ones instead of wrapping.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears the count
//   inc   - count this cycle
//   cnt   - current count
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: hazard controller for the 5-stage RV32I pipeline.
//   Inputs : D-stage sources (Rs1D/Rs2D), E-stage sources/destination and
//            load marker (Rs1E/Rs2E/RdE/RegWriteE/ResultSrcE), taken branch
//            (PCSrcE), M/W destinations (RdM/RdW/RegWriteM/RegWriteW) and the
//            data-memory handshake (MemReqM/MemReadyM).
//   Outputs: forwarding selects (ForwardAE/ForwardBE), stage stalls
//            (StallF/D/E/M), D/E flushes (FlushD/FlushE), sticky memory
//            timeout flag (mem_err) and saturating stall/flush event counters.
module hazard_unit
    import core_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    mem_fsm_t          state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;

    fwd_sel_t fwd_a, fwd_b;
    logic     timeout_hit, mem_stall, lw_stall;
    logic     stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;

    // M has priority because it holds the younger (more recent) write.
    function automatic fwd_sel_t fwd_sel(input logic [4:0] rs);
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs)) return FWD_M;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) return FWD_W;
        else return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (rst_n) begin
            fwd_a = fwd_sel(Rs1E);
            fwd_b = fwd_sel(Rs2E);
        end
    end

    always_comb begin
        // On the last allowed wait cycle the stall is dropped so the pipe
        // moves on and the access is abandoned.
        timeout_hit = (state_q == MEM_WAIT) && (wcnt_q == WCNT_LAST);
        mem_stall   = MemReqM && !MemReadyM && !timeout_hit;
        lw_stall    = RegWriteE && (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst_n) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything; a taken branch waits in E until release.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (PCSrcE) begin
            // The branch is older than the load-use pair, so it wins.
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (MemReqM && !MemReadyM) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = '0;
                end
            end
            MEM_WAIT: begin
                if (!MemReqM || MemReadyM) begin
                    state_d = RUN;
                end else if (timeout_hit) begin
                    state_d   = RUN;
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wcnt_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_f),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_e && rst_n),
        .cnt   (flush_cnt)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;
    assign StallF    = stall_f;
    assign StallD    = stall_d;
    assign StallE    = stall_e;
    assign StallM    = stall_m;
    assign FlushD    = flush_d;
    assign FlushE    = flush_e;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed test of hazard_unit with a short timeout and
// narrow counters so that timeout and saturation are reached quickly.
module tb_hazard_unit;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    logic             clk;
    logic             rst_n;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]       ResultSrcE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_assert;
    int n_fail;

    hazard_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (RegWriteM),
        .RegWriteW  (RegWriteW),
        .MemReqM    (MemReqM),
        .MemReadyM  (MemReadyM),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed as {StallF, StallD, StallE, StallM, FlushD, FlushE}.
    task automatic chk_ctl(input string tag, input logic sf, input logic sd, input logic se,
                           input logic sm, input logic fd, input logic fe);
        chk(tag, 32'({StallF, StallD, StallE, StallM, FlushD, FlushE}),
            32'({sf, sd, se, sm, fd, fe}));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0;
        MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;

        // Reset: forwarding and stalls suppressed, both flushes asserted.
        clear_inputs();
        rst_n = 1'b0;
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; PCSrcE = 1'b1; MemReqM = 1'b1;
        #2;
        chk("rst_fwdA", 32'(ForwardAE), 32'd0);
        chk_ctl("rst_ctl", 0, 0, 0, 0, 1, 1);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_scnt", 32'(stall_cnt), 32'd0);
        chk("rst_fcnt", 32'(flush_cnt), 32'd0);
        tick();
        tick();
        chk("rst_fcnt_hold", 32'(flush_cnt), 32'd0);

        // Forwarding
        clear_inputs();
        rst_n = 1'b1;
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
        #1;
        chk("fwdA_m_prio", 32'(ForwardAE), 32'd2);
        chk_ctl("fwd_ctl", 0, 0, 0, 0, 0, 0);
        RegWriteM = 1'b0;
        #1;
        chk("fwdA_w", 32'(ForwardAE), 32'd1);
        RegWriteM = 1'b1; RdM = 5'd0; Rs1E = 5'd0; RdW = 5'd0;
        #1;
        chk("fwdA_x0", 32'(ForwardAE), 32'd0);
        Rs2E = 5'd9; RdM = 5'd9; RdW = 5'd9; RegWriteM = 1'b0; RegWriteW = 1'b1;
        #1;
        chk("fwdB_w", 32'(ForwardBE), 32'd1);
        RegWriteM = 1'b1;
        #1;
        chk("fwdB_m", 32'(ForwardBE), 32'd2);
        RdM = 5'd3;
        #1;
        chk("fwdB_w_other", 32'(ForwardBE), 32'd1);
        tick();

        // Load-use stall, one cycle
        clear_inputs();
        RegWriteE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        chk_ctl("lw_ctl", 1, 1, 0, 0, 0, 1);
        tick();
        clear_inputs();
        #1;
        chk_ctl("lw_after", 0, 0, 0, 0, 0, 0);
        chk("lw_scnt", 32'(stall_cnt), 32'd1);
        chk("lw_fcnt", 32'(flush_cnt), 32'd1);
        RegWriteE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
        #1;
        chk_ctl("lw_x0", 0, 0, 0, 0, 0, 0);
        tick();

        // Load-use together with a taken branch
        clear_inputs();
        RegWriteE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
        #1;
        chk_ctl("br_lw_ctl", 0, 0, 0, 0, 1, 1);
        tick();
        clear_inputs();
        #1;
        chk("br_fcnt", 32'(flush_cnt), 32'd2);
        chk("br_scnt", 32'(stall_cnt), 32'd1);

        // Memory wait of three cycles, branch held in E until release
        MemReqM = 1'b1; PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ctl("mem_wait", 1, 1, 1, 1, 0, 0);
            tick();
        end
        MemReadyM = 1'b1;
        #1;
        chk_ctl("mem_ready", 0, 0, 0, 0, 1, 1);
        chk("mem_scnt", 32'(stall_cnt), 32'd4);
        tick();
        clear_inputs();
        #1;
        chk("mem_err_ok", 32'(mem_err), 32'd0);
        chk("mem_fcnt", 32'(flush_cnt), 32'd3);

        // Timeout: four stalled cycles, released on the fifth
        MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_ctl("to_wait", 1, 1, 1, 1, 0, 0);
            tick();
        end
        #1;
        chk_ctl("to_release", 0, 0, 0, 0, 0, 0);
        chk("to_err_pre", 32'(mem_err), 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("to_err_set", 32'(mem_err), 32'd1);
        chk("to_scnt", 32'(stall_cnt), 32'd8);
        tick();
        chk("to_err_sticky", 32'(mem_err), 32'd1);

        // Counter saturation
        RegWriteE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
        repeat (9) tick();
        clear_inputs();
        #1;
        chk("sat_scnt", 32'(stall_cnt), 32'd15);
        chk("sat_fcnt_mid", 32'(flush_cnt), 32'd12);
        PCSrcE = 1'b1;
        #1;
        chk_ctl("sat_br_ctl", 0, 0, 0, 0, 1, 1);
        repeat (5) tick();
        clear_inputs();
        #1;
        chk("sat_fcnt", 32'(flush_cnt), 32'd15);
        chk("sat_scnt_hold", 32'(stall_cnt), 32'd15);

        // Reset in the middle of a memory wait
        MemReqM = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_ctl("rstw_ctl", 0, 0, 0, 0, 1, 1);
        chk("rstw_scnt", 32'(stall_cnt), 32'd0);
        chk("rstw_fcnt", 32'(flush_cnt), 32'd0);
        chk("rstw_err", 32'(mem_err), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_ctl("rstw_wait", 1, 1, 1, 1, 0, 0);
            tick();
        end
        #1;
        chk_ctl("rstw_release", 0, 0, 0, 0, 0, 0);
        chk("rstw_scnt_after", 32'(stall_cnt), 32'd4);
        tick();
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
